// File: rtl/vita49_pkg.sv
// Shared types and constants for the VITA-49 IF data packet framer.
// VITA49_PACK_TRAILER_EN adds the trailer state.
package vita49_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StHdr,
    StSid,
    StTsi,
    StTsfHi,
    StTsfLo,
    StPayload,
    StPad
`ifdef VITA49_PACK_TRAILER_EN
    , StTrailer
`endif
  } state_e;

  localparam logic [3:0] PKT_TYPE_IF_SID = 4'b0001;
  localparam logic [1:0] TSI_UTC         = 2'b01;
  localparam logic [1:0] TSF_RT          = 2'b10;

  localparam int unsigned HDR_WORDS   = 5;
  localparam int unsigned TRL_VDE_BIT = 30;
  localparam int unsigned TRL_VD_BIT  = 18;

  function automatic logic [31:0] trailer_word(input logic pad);
    logic [31:0] w;
    w              = '0;
    w[TRL_VDE_BIT] = 1'b1;
    w[TRL_VD_BIT]  = ~pad;
    return w;
  endfunction

endpackage

// File: rtl/vita49_hdr_word.sv
// Assembles the VITA-49 IF data header word from packet count, size and trailer flag.
module vita49_hdr_word
  import vita49_pkg::*;
(
  input  logic [3:0]  count,
  input  logic [15:0] size,
  input  logic        trailer,
  output logic [31:0] word
);

  assign word = {PKT_TYPE_IF_SID, 1'b0, trailer, 2'b00, TSI_UTC, TSF_RT, count, size};

endmodule

// File: rtl/vita49_pack.sv
// Transmit-side VITA-49 framer: wraps an AXIS sample stream into IF data packets.
// Define VITA49_PACK_TRAILER_EN to append a trailer word to every packet.
module vita49_pack
  import vita49_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_NUM_BYTES = 4,
  parameter int unsigned C_PKT_SIZE_W           = 16
) (
  input  logic                    AXIS_ACLK,
  input  logic                    AXIS_ARESET,
  input  logic [31:0]             S_AXIS_TDATA,
  input  logic [3:0]              S_AXIS_TSTRB,
  input  logic                    S_AXIS_TLAST,
  input  logic                    S_AXIS_TVALID,
  output logic                    S_AXIS_TREADY,
  output logic [31:0]             M_AXIS_TDATA,
  output logic [3:0]              M_AXIS_TSTRB,
  output logic                    M_AXIS_TLAST,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  input  logic [31:0]             ctrl,
  input  logic [C_PKT_SIZE_W-1:0] pkt_size,
  input  logic [31:0]             stream_id,
  input  logic [31:0]             tsi,
  input  logic [63:0]             tsf,
  output logic [31:0]             status
);

`ifdef VITA49_PACK_TRAILER_EN
  localparam logic TRAILER = 1'b1;
`else
  localparam logic TRAILER = 1'b0;
`endif
  localparam logic [C_PKT_SIZE_W-1:0] ONE = 1;

  state_e                  state_q;
  logic [C_PKT_SIZE_W-1:0] n_q, word_cnt_q, n_next, cnt_last;
  logic [31:0]             sid_q, tsi_q;
  logic [63:0]             tsf_q;
  logic [3:0]              pkt_cnt_q;
  logic [15:0]             sent_q;
  logic                    sticky_q, pad_evt_q;
  logic [31:0]             out_data_q;
  logic                    out_valid_q, out_last_q;
  logic [15:0]             hdr_size;
  logic [31:0]             hdr_word;
  logic                    m_fire;
  logic                    unused_sig;

  assign unused_sig   = ^{S_AXIS_TSTRB, ctrl[31:3], pad_evt_q};
  assign M_AXIS_TSTRB = {C_AXIS_TDATA_NUM_BYTES{1'b1}};

  assign n_next   = (pkt_size == '0) ? ONE : pkt_size;
  assign cnt_last = n_q - ONE;
  assign hdr_size = 16'(n_next) + 16'(HDR_WORDS) + 16'(TRAILER);

  vita49_hdr_word u_hdr_word (
    .count   (pkt_cnt_q),
    .size    (hdr_size),
    .trailer (TRAILER),
    .word    (hdr_word)
  );

  // Payload words bypass the output registers so the source sees sink back-pressure directly.
  always_comb begin
    if (state_q == StPayload) begin
      M_AXIS_TVALID = S_AXIS_TVALID;
      M_AXIS_TDATA  = S_AXIS_TDATA;
      M_AXIS_TLAST  = ~TRAILER & (word_cnt_q == cnt_last);
      S_AXIS_TREADY = M_AXIS_TREADY;
    end else begin
      M_AXIS_TVALID = out_valid_q;
      M_AXIS_TDATA  = out_data_q;
      M_AXIS_TLAST  = out_last_q;
      S_AXIS_TREADY = 1'b0;
    end
  end

  assign m_fire = M_AXIS_TVALID & M_AXIS_TREADY;
  assign status = {sent_q, 10'b0, pkt_cnt_q, sticky_q, state_q != StIdle};

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET || ctrl[1]) begin
      state_q     <= StIdle;
      n_q         <= ONE;
      word_cnt_q  <= '0;
      sid_q       <= '0;
      tsi_q       <= '0;
      tsf_q       <= '0;
      pkt_cnt_q   <= '0;
      sent_q      <= '0;
      sticky_q    <= 1'b0;
      pad_evt_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      // A pad event later in this block overrides the clear.
      if (ctrl[2]) sticky_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ctrl[0] && S_AXIS_TVALID) begin
            state_q     <= StHdr;
            n_q         <= n_next;
            sid_q       <= stream_id;
            tsi_q       <= tsi;
            tsf_q       <= tsf;
            word_cnt_q  <= '0;
            pad_evt_q   <= 1'b0;
            out_data_q  <= hdr_word;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
          end
        end
        StHdr: if (M_AXIS_TREADY) begin
          state_q    <= StSid;
          out_data_q <= sid_q;
        end
        StSid: if (M_AXIS_TREADY) begin
          state_q    <= StTsi;
          out_data_q <= tsi_q;
        end
        StTsi: if (M_AXIS_TREADY) begin
          state_q    <= StTsfHi;
          out_data_q <= tsf_q[63:32];
        end
        StTsfHi: if (M_AXIS_TREADY) begin
          state_q    <= StTsfLo;
          out_data_q <= tsf_q[31:0];
        end
        StTsfLo: if (M_AXIS_TREADY) begin
          state_q     <= StPayload;
          out_data_q  <= '0;
          out_valid_q <= 1'b0;
        end
        StPayload: begin
          if (m_fire) begin
            word_cnt_q <= word_cnt_q + ONE;
            if (word_cnt_q == cnt_last) begin
`ifdef VITA49_PACK_TRAILER_EN
              state_q     <= StTrailer;
              out_data_q  <= trailer_word(pad_evt_q);
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b1;
`else
              state_q   <= StIdle;
              pkt_cnt_q <= pkt_cnt_q + 4'd1;
              sent_q    <= sent_q + 16'd1;
`endif
            end else if (S_AXIS_TLAST) begin
              state_q     <= StPad;
              out_data_q  <= '0;
              out_valid_q <= 1'b1;
              out_last_q  <= ~TRAILER & ((word_cnt_q + ONE) == cnt_last);
              sticky_q    <= 1'b1;
              pad_evt_q   <= 1'b1;
            end
          end
        end
        StPad: if (M_AXIS_TREADY) begin
          word_cnt_q <= word_cnt_q + ONE;
          if (word_cnt_q == cnt_last) begin
`ifdef VITA49_PACK_TRAILER_EN
            state_q    <= StTrailer;
            out_data_q <= trailer_word(1'b1);
            out_last_q <= 1'b1;
`else
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            pkt_cnt_q   <= pkt_cnt_q + 4'd1;
            sent_q      <= sent_q + 16'd1;
`endif
          end else begin
            out_last_q <= ~TRAILER & ((word_cnt_q + ONE) == cnt_last);
          end
        end
`ifdef VITA49_PACK_TRAILER_EN
        StTrailer: if (M_AXIS_TREADY) begin
          state_q     <= StIdle;
          out_data_q  <= '0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          pkt_cnt_q   <= pkt_cnt_q + 4'd1;
          sent_q      <= sent_q + 16'd1;
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vita49_pack.sv
// Self-checking bench for vita49_pack: packet-level model plus directed literal checks.
module tb_vita49_pack;

`ifdef VITA49_PACK_TRAILER_EN
  localparam bit T = 1'b1;
`else
  localparam bit T = 1'b0;
`endif

  logic        clk;
  logic        AXIS_ARESET;
  logic [31:0] S_AXIS_TDATA;
  logic [3:0]  S_AXIS_TSTRB;
  logic        S_AXIS_TLAST, S_AXIS_TVALID, S_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0]  M_AXIS_TSTRB;
  logic        M_AXIS_TLAST, M_AXIS_TVALID, M_AXIS_TREADY;
  logic [31:0] ctrl, stream_id, tsi, status;
  logic [15:0] pkt_size;
  logic [63:0] tsf;

  vita49_pack dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (AXIS_ARESET),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TSTRB  (S_AXIS_TSTRB),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TSTRB  (M_AXIS_TSTRB),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .ctrl          (ctrl),
    .pkt_size      (pkt_size),
    .stream_id     (stream_id),
    .tsi           (tsi),
    .tsf           (tsf),
    .status        (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [31:0] data; logic last;} src_t;
  typedef struct {logic [31:0] data; logic last; bit is_pay;} exp_t;

  src_t        src_q[$];
  exp_t        exp_q[$];
  logic [31:0] got_q[$];
  int          n_cmp = 0, n_err = 0;
  int          mdl_cnt = 0, mdl_sent = 0;
  bit          mdl_sticky = 1'b0;
  int          rdy_mode = 0;
  int          cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Header from the field layout: type, T, TSI/TSF codes, count, total size.
  function automatic logic [31:0] mdl_hdr(input int cnt, input int n);
    logic [31:0] w;
    w = 32'h1000_0000 | 32'h0040_0000 | 32'h0020_0000;
    if (T) w = w | 32'h0400_0000;
    w = w | (32'(cnt % 16) << 16) | (32'(5 + n + int'(T)) & 32'h0000_FFFF);
    return w;
  endfunction

  function automatic logic [31:0] mdl_status();
    return {16'(mdl_sent), 10'b0, 4'(mdl_cnt), mdl_sticky, 1'b0};
  endfunction

  task automatic push_exp(input logic [31:0] d, input logic l, input bit p);
    exp_q.push_back('{data: d, last: l, is_pay: p});
  endtask

  // Queue nsamp source samples and the packet words they must produce.
  task automatic push_packet(input int psize, input int nsamp, input bit end_tlast,
                             input logic [31:0] base);
    int n;
    n = (psize == 0) ? 1 : psize;
    push_exp(mdl_hdr(mdl_cnt, n), 1'b0, 1'b0);
    push_exp(stream_id, 1'b0, 1'b0);
    push_exp(tsi, 1'b0, 1'b0);
    push_exp(tsf[63:32], 1'b0, 1'b0);
    push_exp(tsf[31:0], 1'b0, 1'b0);
    for (int i = 0; i < nsamp; i++) begin
      src_q.push_back('{data: base + 32'(i), last: end_tlast && (i == nsamp - 1)});
      push_exp(base + 32'(i), !T && (i == n - 1), 1'b1);
    end
    for (int i = nsamp; i < n; i++) push_exp(32'h0, !T && (i == n - 1), 1'b0);
    if (T) push_exp((nsamp < n) ? 32'h4000_0000 : 32'h4004_0000, 1'b1, 1'b0);
    if (nsamp < n) mdl_sticky = 1'b1;
    mdl_cnt  = (mdl_cnt + 1) % 16;
    mdl_sent = mdl_sent + 1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0) && k < budget) begin
      step();
      k++;
    end
    chk({name, "_complete"}, 64'(exp_q.size() + src_q.size()), 64'd0);
    step();
    step();
  endtask

  // Drive source and sink-ready, then compare every output handshake against the model.
  initial begin : bus
    logic [3:0]  tog;
    logic        hold_prev, s_fire, last_prev;
    logic [31:0] data_prev;
    exp_t        e;
    tog       = 4'b1001;
    hold_prev = 1'b0;
    data_prev = '0;
    last_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      case (rdy_mode)
        0:       M_AXIS_TREADY = 1'b1;
        1:       M_AXIS_TREADY = tog[cyc % 4];
        default: M_AXIS_TREADY = 1'b0;
      endcase
      if (src_q.size() != 0) begin
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = src_q[0].data;
        S_AXIS_TLAST  = src_q[0].last;
      end else begin
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TLAST  = 1'b0;
      end
      #2;
      if (hold_prev) begin
        chk("stall_valid", M_AXIS_TVALID, 1'b1);
        chk("stall_data", M_AXIS_TDATA, data_prev);
        chk("stall_last", M_AXIS_TLAST, last_prev);
      end
      if (exp_q.size() != 0 && !exp_q[0].is_pay) chk("sready_hdr", S_AXIS_TREADY, 1'b0);
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 64'(M_AXIS_TDATA), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("word", M_AXIS_TDATA, e.data);
          chk("tlast", M_AXIS_TLAST, e.last);
        end
        got_q.push_back(M_AXIS_TDATA);
      end
      s_fire    = S_AXIS_TVALID && S_AXIS_TREADY;
      hold_prev = M_AXIS_TVALID && !M_AXIS_TREADY && !AXIS_ARESET && !ctrl[1];
      data_prev = M_AXIS_TDATA;
      last_prev = M_AXIS_TLAST;
      cyc++;
      @(posedge clk);
      if (s_fire && src_q.size() != 0) void'(src_q.pop_front());
    end
  end

  initial begin : watchdog
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : main
    logic [31:0] lit1 [9];
    logic [31:0] w;
    AXIS_ARESET   = 1'b1;
    ctrl          = '0;
    pkt_size      = 16'd4;
    stream_id     = '0;
    tsi           = '0;
    tsf           = '0;
    S_AXIS_TSTRB  = 4'h0;
    S_AXIS_TDATA  = '0;
    S_AXIS_TLAST  = 1'b0;
    S_AXIS_TVALID = 1'b0;
    M_AXIS_TREADY = 1'b0;
    repeat (3) step();
    chk("rst_tvalid", M_AXIS_TVALID, 1'b0);
    chk("rst_tlast", M_AXIS_TLAST, 1'b0);
    chk("rst_sready", S_AXIS_TREADY, 1'b0);
    chk("rst_tdata", M_AXIS_TDATA, 32'h0);
    chk("rst_status", status, 32'h0);
    chk("tstrb", M_AXIS_TSTRB, 4'hF);
    AXIS_ARESET = 1'b0;
    step();

    // Two 4-sample packets from one continuous 8-sample run
    stream_id = 32'hCAFE_0001;
    tsi       = 32'd100;
    tsf       = 64'h0000_0001_0000_0002;
    pkt_size  = 16'd4;
    ctrl      = 32'h1;
    got_q.delete();
    push_packet(4, 4, 1'b0, 32'd1);
    push_packet(4, 4, 1'b0, 32'd5);
`ifndef VITA49_PACK_TRAILER_EN
    chk("model_hdr0", exp_q[0].data, 32'h1060_0009);
`endif
    drain("basic", 300);
`ifndef VITA49_PACK_TRAILER_EN
    // Literal header values follow the field layout (TSI=01, TSF=10 codes present)
    lit1 = '{32'h1060_0009, 32'hCAFE_0001, 32'h0000_0064, 32'h0000_0001, 32'h0000_0002,
             32'h1, 32'h2, 32'h3, 32'h4};
    for (int i = 0; i < 9; i++) chk($sformatf("pkt1_w%0d", i), got_q[i], lit1[i]);
    chk("pkt2_hdr", got_q[9], 32'h1061_0009);
`endif
    chk("basic_status", status, mdl_status());

    // Sink stalls 1,0,0,1; last packet ends with source TLAST exactly on word N
    rdy_mode  = 1;
    stream_id = 32'h0BAD_F00D;
    tsi       = 32'h1234_5678;
    tsf       = 64'hAAAA_BBBB_CCCC_DDDD;
    pkt_size  = 16'd3;
    push_packet(3, 3, 1'b0, 32'h100);
    push_packet(3, 3, 1'b1, 32'h200);
    drain("stall", 400);
    chk("stall_status", status, mdl_status());

    // Early source TLAST forces zero padding, still under stalls
    pkt_size = 16'd6;
    push_packet(6, 3, 1'b1, 32'hA0);
    drain("pad", 400);
    chk("pad_sticky", status[1], 1'b1);
    chk("pad_status", status, mdl_status());
    ctrl = 32'h5;
    step();
    ctrl       = 32'h1;
    mdl_sticky = 1'b0;
    step();
    chk("sticky_clear", status[1], 1'b0);

    // Soft reset, then 17 single-word packets (size 0 behaves as 1)
    rdy_mode = 0;
    ctrl     = 32'h3;
    step();
    ctrl     = 32'h1;
    mdl_cnt  = 0;
    mdl_sent = 0;
    chk("soft_rst_status", status, 32'h0);
    pkt_size = 16'd0;
    got_q.delete();
    for (int p = 0; p < 17; p++) push_packet(0, 1, 1'b1, 32'h1000 + 32'(p));
    drain("wrap", 600);
    chk("wrap_sent", status[31:16], 16'd17);
    chk("wrap_cnt", status[5:2], 4'd1);
    chk("wrap_status", status, mdl_status());
`ifndef VITA49_PACK_TRAILER_EN
    chk("wrap_hdr16", got_q[16 * 6], 32'h1060_0006);
    chk("wrap_hdr15", got_q[15 * 6], 32'h106F_0006);
`endif

    // Hard reset while the TSI word is on the bus
    pkt_size = 16'd2;
    tsi      = 32'h0000_0777;
    got_q.delete();
    push_packet(2, 2, 1'b0, 32'h55);
    begin
      int k;
      k = 0;
      while (got_q.size() < 2 && k < 40) begin
        step();
        k++;
      end
    end
    chk("at_tsi_data", M_AXIS_TDATA, 32'h0000_0777);
    AXIS_ARESET = 1'b1;
    rdy_mode    = 2;
    ctrl        = 32'h0;
    src_q.delete();
    step();
    AXIS_ARESET = 1'b0;
    exp_q.delete();
    mdl_cnt    = 0;
    mdl_sent   = 0;
    mdl_sticky = 1'b0;
    chk("mid_rst_tvalid", M_AXIS_TVALID, 1'b0);
    chk("mid_rst_status", status, 32'h0);
    chk("mid_rst_tdata", M_AXIS_TDATA, 32'h0);
    ctrl     = 32'h1;
    rdy_mode = 1;
    got_q.delete();
    push_packet(2, 2, 1'b1, 32'h77);
    drain("after_rst", 200);
    w = got_q[0];
    chk("after_rst_cnt", w[19:16], 4'd0);

`ifdef VITA49_PACK_TRAILER_EN
    rdy_mode = 0;
    pkt_size = 16'd2;
    got_q.delete();
    push_packet(2, 2, 1'b0, 32'h99);
    chk("model_trl_hdr", exp_q[0].data, 32'h1461_0008);
    drain("trailer", 200);
    chk("trl_hdr", got_q[0], 32'h1461_0008);
    chk("trl_word", got_q[7], 32'h4004_0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
